// File: rtl/mmio_controller.sv
// Memory-mapped IO block sitting beside a dual-port RAM: decodes an 8-word IO window,
// gates RAM write strobes and muxes registered IO read data onto each CPU port.
module mmio_controller #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           IN_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'hFFF8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] write_data_a,
    input  logic [DATA_WIDTH-1:0] write_data_b,
    input  logic                  write_enable_a,
    input  logic                  write_enable_b,
    input  logic [DATA_WIDTH-1:0] mem_read_data_a,
    input  logic [DATA_WIDTH-1:0] mem_read_data_b,
    output logic                  mem_write_enable_a,
    output logic                  mem_write_enable_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic [IN_WIDTH-1:0]   io_in,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic                  irq
);

    logic [IN_WIDTH-1:0]   r_sync1;
    logic [IN_WIDTH-1:0]   r_sync2;
    logic [IN_WIDTH-1:0]   r_prev;
    logic [IN_WIDTH-1:0]   r_edge;
    logic [IN_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic                  r_irq;
    logic                  r_rd_flag_a;
    logic                  r_rd_flag_b;
    logic [DATA_WIDTH-1:0] r_rd_val_a;
    logic [DATA_WIDTH-1:0] r_rd_val_b;

    logic                  w_win_a;
    logic                  w_win_b;
    logic [2:0]            w_off_a;
    logic [2:0]            w_off_b;
    logic [7:0]            w_hit_a;
    logic [7:0]            w_hit_b;
    logic [7:0]            w_wr_v;
    logic [DATA_WIDTH-1:0] w_wdata [8];
    logic [DATA_WIDTH-1:0] w_regs  [8];
    logic [IN_WIDTH-1:0]   w_edge_clr;
    logic [IN_WIDTH-1:0]   w_edge_set;

    assign w_win_a = (address_a[ADDR_WIDTH-1:3] == IO_BASE[ADDR_WIDTH-1:3]);
    assign w_win_b = (address_b[ADDR_WIDTH-1:3] == IO_BASE[ADDR_WIDTH-1:3]);
    assign w_off_a = address_a[2:0];
    assign w_off_b = address_b[2:0];

    assign mem_write_enable_a = write_enable_a & ~w_win_a;
    assign mem_write_enable_b = write_enable_b & ~w_win_b;

    // Port A owns any register both ports hit in the same cycle.
    always_comb begin
        w_hit_a = (write_enable_a && w_win_a) ? (8'b1 << w_off_a) : 8'b0;
        w_hit_b = (write_enable_b && w_win_b) ? (8'b1 << w_off_b) : 8'b0;
        w_wr_v  = w_hit_a | w_hit_b;
        for (int k = 0; k < 8; k++) begin
            w_wdata[k] = w_hit_a[k] ? write_data_a : write_data_b;
        end
    end

    always_comb begin
        w_regs[0] = DATA_WIDTH'(r_sync2);
        w_regs[1] = DATA_WIDTH'(r_sync2 >> 4);
        w_regs[2] = DATA_WIDTH'(r_edge);
        w_regs[3] = DATA_WIDTH'(r_mask);
        w_regs[4] = r_out;
        w_regs[5] = r_cycle;
        w_regs[6] = '0;
        w_regs[7] = '0;
    end

    assign w_edge_set = r_sync2 & ~r_prev;
    assign w_edge_clr = w_wr_v[2] ? w_wdata[2][IN_WIDTH-1:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_edge      <= '0;
            r_mask      <= '0;
            r_out       <= '0;
            r_cycle     <= '0;
            r_irq       <= 1'b0;
            r_rd_flag_a <= 1'b0;
            r_rd_flag_b <= 1'b0;
            r_rd_val_a  <= '0;
            r_rd_val_b  <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A fresh rising edge survives a same-cycle clear.
            r_edge  <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr_v[3]) begin
                r_mask <= w_wdata[3][IN_WIDTH-1:0];
            end
            if (w_wr_v[4]) begin
                r_out <= w_wdata[4];
            end
            r_cycle     <= w_wr_v[5] ? w_wdata[5] : r_cycle + DATA_WIDTH'(1);
            r_irq       <= |(r_edge & r_mask);
            r_rd_flag_a <= w_win_a;
            r_rd_flag_b <= w_win_b;
            r_rd_val_a  <= w_regs[w_off_a];
            r_rd_val_b  <= w_regs[w_off_b];
        end
    end

    assign read_data_a = r_rd_flag_a ? r_rd_val_a : mem_read_data_a;
    assign read_data_b = r_rd_flag_b ? r_rd_val_b : mem_read_data_b;
    assign io_out      = r_out;
    assign irq         = r_irq;

endmodule

// File: tb/tb_mmio_controller.sv
// Self-checking bench for mmio_controller: directed scenarios plus a randomized run
// compared against a register-file model of the IO window.
module tb_mmio_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address_a, address_b;
    logic [15:0] write_data_a, write_data_b;
    logic        write_enable_a, write_enable_b;
    logic [15:0] mem_read_data_a, mem_read_data_b;
    logic        mem_write_enable_a, mem_write_enable_b;
    logic [15:0] read_data_a, read_data_b;
    logic [7:0]  io_in;
    logic [15:0] io_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mmio_controller dut (
        .clock              (clock),
        .reset              (reset),
        .address_a          (address_a),
        .address_b          (address_b),
        .write_data_a       (write_data_a),
        .write_data_b       (write_data_b),
        .write_enable_a     (write_enable_a),
        .write_enable_b     (write_enable_b),
        .mem_read_data_a    (mem_read_data_a),
        .mem_read_data_b    (mem_read_data_b),
        .mem_write_enable_a (mem_write_enable_a),
        .mem_write_enable_b (mem_write_enable_b),
        .read_data_a        (read_data_a),
        .read_data_b        (read_data_b),
        .io_in              (io_in),
        .io_out             (io_out),
        .irq                (irq)
    );

    always #5 clock = ~clock;

    // Reference model: io_in sample history plus the architectural register contents.
    logic [7:0]  m_s1, m_s2, m_prev, m_edge, m_mask;
    logic [15:0] m_out, m_cycle;
    logic        m_irq;
    logic        m_rf_a, m_rf_b;
    logic [15:0] m_rv_a, m_rv_b;

    function automatic bit in_win(input logic [15:0] a);
        return a >= 16'hFFF8;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return {8'h00, m_s2};
            3'd1:    return {12'h000, m_s2[7:4]};
            3'd2:    return {8'h00, m_edge};
            3'd3:    return {8'h00, m_mask};
            3'd4:    return m_out;
            3'd5:    return m_cycle;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_edge = 0; m_mask = 0;
        m_out = 0; m_cycle = 0; m_irq = 0;
        m_rf_a = 0; m_rf_b = 0; m_rv_a = 0; m_rv_b = 0;
    endtask

    task automatic set_idle();
        write_enable_a = 0; write_enable_b = 0;
        address_a = 16'h0000; address_b = 16'h0002;
        write_data_a = 16'h0000; write_data_b = 16'h0000;
    endtask

    // One clock: predict from pre-edge inputs, advance, then refresh RAM data.
    task automatic tick();
        logic [15:0] wd [8];
        bit          wv [8];
        logic [7:0]  clr, n_edge, n_mask, s_in;
        logic [15:0] n_out, n_cycle, n_rv_a, n_rv_b;
        bit          n_rf_a, n_rf_b, n_irq;
        for (int k = 0; k < 8; k++) begin
            wv[k] = 0;
            wd[k] = 16'h0000;
        end
        if (write_enable_b && in_win(address_b)) begin
            wv[address_b[2:0]] = 1;
            wd[address_b[2:0]] = write_data_b;
        end
        if (write_enable_a && in_win(address_a)) begin
            wv[address_a[2:0]] = 1;
            wd[address_a[2:0]] = write_data_a;
        end
        n_rf_a  = in_win(address_a);
        n_rf_b  = in_win(address_b);
        n_rv_a  = m_read(address_a[2:0]);
        n_rv_b  = m_read(address_b[2:0]);
        clr     = wv[2] ? wd[2][7:0] : 8'h00;
        n_edge  = (m_edge & ~clr) | (m_s2 & ~m_prev);
        n_mask  = wv[3] ? wd[3][7:0] : m_mask;
        n_out   = wv[4] ? wd[4] : m_out;
        n_cycle = wv[5] ? wd[5] : m_cycle + 16'd1;
        n_irq   = (m_edge & m_mask) != 8'h00;
        s_in    = io_in;
        @(posedge clock);
        #1;
        if (reset) begin
            m_reset();
        end else begin
            m_prev = m_s2; m_s2 = m_s1; m_s1 = s_in;
            m_edge = n_edge; m_mask = n_mask; m_out = n_out; m_cycle = n_cycle;
            m_irq = n_irq;
            m_rf_a = n_rf_a; m_rf_b = n_rf_b; m_rv_a = n_rv_a; m_rv_b = n_rv_b;
        end
        mem_read_data_a = 16'($urandom);
        mem_read_data_b = 16'($urandom);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; io_in = 8'h00;
        set_idle();
        mem_read_data_a = 16'h1234; mem_read_data_b = 16'h5678;
        m_reset();
        tick();
        tick();
        checks++;
        if (io_out !== 16'h0000) begin
            failures++; $display("FAIL reset_io_out got=%h exp=0000", io_out);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        checks++;
        if (read_data_a !== mem_read_data_a || read_data_b !== mem_read_data_b) begin
            failures++;
            $display("FAIL reset_rd_pass got=%h/%h exp=%h/%h", read_data_a, read_data_b,
                     mem_read_data_a, mem_read_data_b);
        end
        #2;
        reset = 0;
    endtask

    task automatic test_out_write();
        address_a = 16'hFFFC; write_data_a = 16'hA5A5; write_enable_a = 1;
        #1;
        checks++;
        if (mem_write_enable_a !== 1'b0) begin
            failures++; $display("FAIL out_gate_pre got=%b exp=0", mem_write_enable_a);
        end
        tick();
        checks++;
        if (io_out !== 16'hA5A5) begin
            failures++; $display("FAIL out_io_out got=%h exp=a5a5", io_out);
        end
        checks++;
        if (mem_write_enable_a !== 1'b0) begin
            failures++; $display("FAIL out_gate_post got=%b exp=0", mem_write_enable_a);
        end
        set_idle();
        address_b = 16'hFFFC;
        tick();
        checks++;
        if (read_data_b !== 16'hA5A5) begin
            failures++; $display("FAIL out_readback got=%h exp=a5a5", read_data_b);
        end
    endtask

    task automatic test_sync_edge();
        set_idle();
        io_in = 8'h00;
        repeat (3) tick();
        address_b = 16'hFFFA; write_data_b = 16'h00FF; write_enable_b = 1;
        tick();
        set_idle();
        io_in = 8'h3C;
        address_a = 16'hFFF8; address_b = 16'hFFF9;
        tick();
        tick();
        checks++;
        if (read_data_a !== 16'h0000) begin
            failures++; $display("FAIL sync_early got=%h exp=0000", read_data_a);
        end
        tick();
        checks++;
        if (read_data_a !== 16'h003C) begin
            failures++; $display("FAIL sync_off0 got=%h exp=003c", read_data_a);
        end
        checks++;
        if (read_data_b !== 16'h0003) begin
            failures++; $display("FAIL sync_off1 got=%h exp=0003", read_data_b);
        end
        address_a = 16'hFFFA;
        tick();
        checks++;
        if (read_data_a !== 16'h003C) begin
            failures++; $display("FAIL edge_flags got=%h exp=003c", read_data_a);
        end
    endtask

    task automatic test_irq();
        set_idle();
        io_in = 8'h00;
        address_a = 16'hFFFB; write_data_a = 16'h0004; write_enable_a = 1;
        tick();
        set_idle();
        repeat (3) tick();
        address_b = 16'hFFFA; write_data_b = 16'h00FF; write_enable_b = 1;
        tick();
        set_idle();
        io_in = 8'h04;
        repeat (3) tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_lag got=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_rise got=%b exp=1", irq);
        end
        io_in = 8'h00;
        repeat (3) tick();
        io_in = 8'h04;
        repeat (2) tick();
        address_b = 16'hFFFA; write_data_b = 16'h0004; write_enable_b = 1;
        tick();
        set_idle();
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_set_win got=%b exp=1", irq);
        end
        address_a = 16'hFFFA;
        tick();
        checks++;
        if (read_data_a !== 16'h0004) begin
            failures++; $display("FAIL edge_set_win got=%h exp=0004", read_data_a);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_hold got=%b exp=1", irq);
        end
        address_b = 16'hFFFA; write_data_b = 16'h0004; write_enable_b = 1;
        tick();
        set_idle();
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_dual_write();
        set_idle();
        address_a = 16'hFFFC; write_data_a = 16'h1111; write_enable_a = 1;
        address_b = 16'hFFFC; write_data_b = 16'h2222; write_enable_b = 1;
        tick();
        checks++;
        if (io_out !== 16'h1111) begin
            failures++; $display("FAIL same_reg_a_wins got=%h exp=1111", io_out);
        end
        address_a = 16'hFFFB; write_data_a = 16'h0010;
        address_b = 16'hFFFC; write_data_b = 16'h0020;
        tick();
        set_idle();
        checks++;
        if (io_out !== 16'h0020) begin
            failures++; $display("FAIL diff_reg_out got=%h exp=0020", io_out);
        end
        address_a = 16'hFFFB;
        tick();
        checks++;
        if (read_data_a !== 16'h0010) begin
            failures++; $display("FAIL diff_reg_mask got=%h exp=0010", read_data_a);
        end
    endtask

    task automatic test_cycle();
        set_idle();
        address_a = 16'hFFFC; write_data_a = 16'hBEEF; write_enable_a = 1;
        address_b = 16'hFFFD; write_data_b = 16'hFFFF; write_enable_b = 1;
        tick();
        set_idle();
        address_a = 16'hFFFD;
        tick();
        checks++;
        if (read_data_a !== 16'hFFFF) begin
            failures++; $display("FAIL cycle_load got=%h exp=ffff", read_data_a);
        end
        tick();
        checks++;
        if (read_data_a !== 16'h0000) begin
            failures++; $display("FAIL cycle_wrap got=%h exp=0000", read_data_a);
        end
        tick();
        checks++;
        if (read_data_a !== 16'h0001) begin
            failures++; $display("FAIL cycle_after_wrap got=%h exp=0001", read_data_a);
        end
        reset = 1;
        m_reset();
        #1;
        checks++;
        if (io_out !== 16'h0000) begin
            failures++; $display("FAIL async_rst_out got=%h exp=0000", io_out);
        end
        checks++;
        if (read_data_a !== mem_read_data_a) begin
            failures++;
            $display("FAIL async_rst_rd got=%h exp=%h", read_data_a, mem_read_data_a);
        end
        reset = 0;
        #1;
        tick();
        checks++;
        if (read_data_a !== 16'h0000) begin
            failures++; $display("FAIL cycle_restart0 got=%h exp=0000", read_data_a);
        end
        tick();
        checks++;
        if (read_data_a !== 16'h0001) begin
            failures++; $display("FAIL cycle_restart1 got=%h exp=0001", read_data_a);
        end
    endtask

    task automatic test_passthru();
        set_idle();
        io_in = 8'h5A;
        repeat (3) tick();
        address_a = 16'h0100; write_data_a = 16'h7777; write_enable_a = 1;
        address_b = 16'hFFF8;
        #1;
        checks++;
        if (mem_write_enable_a !== 1'b1) begin
            failures++; $display("FAIL ram_we_pass got=%b exp=1", mem_write_enable_a);
        end
        tick();
        set_idle();
        checks++;
        if (read_data_a !== mem_read_data_a) begin
            failures++; $display("FAIL ram_rd_pass got=%h exp=%h", read_data_a, mem_read_data_a);
        end
        checks++;
        if (read_data_b !== 16'h005A) begin
            failures++; $display("FAIL io_rd_sync got=%h exp=005a", read_data_b);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_a, exp_b;
        for (int n = 0; n < 500; n++) begin
            address_a = ($urandom_range(0, 1) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                                    : 16'($urandom_range(0, 16'hFFF7));
            address_b = ($urandom_range(0, 1) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                                    : 16'($urandom_range(0, 16'hFFF7));
            write_enable_a = ($urandom_range(0, 2) == 0);
            write_enable_b = ($urandom_range(0, 2) == 0);
            write_data_a   = 16'($urandom);
            write_data_b   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) io_in = 8'($urandom);
            #1;
            checks++;
            if (mem_write_enable_a !== (write_enable_a && !in_win(address_a)) ||
                mem_write_enable_b !== (write_enable_b && !in_win(address_b))) begin
                failures++;
                $display("FAIL rnd_mem_we n=%0d got=%b%b", n, mem_write_enable_a,
                         mem_write_enable_b);
            end
            tick();
            exp_a = m_rf_a ? m_rv_a : mem_read_data_a;
            exp_b = m_rf_b ? m_rv_b : mem_read_data_b;
            checks++;
            if (read_data_a !== exp_a) begin
                failures++; $display("FAIL rnd_rd_a n=%0d got=%h exp=%h", n, read_data_a, exp_a);
            end
            checks++;
            if (read_data_b !== exp_b) begin
                failures++; $display("FAIL rnd_rd_b n=%0d got=%h exp=%h", n, read_data_b, exp_b);
            end
            checks++;
            if (io_out !== m_out) begin
                failures++; $display("FAIL rnd_io_out n=%0d got=%h exp=%h", n, io_out, m_out);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_irq);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_sync_edge();
        test_irq();
        test_dual_write();
        test_cycle();
        test_passthru();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
